// File: rtl/frame_checker_multiflow.sv
// frame_checker_multiflow: AXIS register slice that snoops test headers on each frame's first beat
// and keeps per-flow frame/byte/lost/out-of-order counters plus a global bad-header counter.
module frame_checker_multiflow #(
   parameter int          DATA_WIDTH = 512,
   parameter int          ID_WIDTH   = 3,
   parameter int          NUM_FLOWS  = 4,
   parameter int          SEQ_WIDTH  = 32,
   parameter int          CNT_WIDTH  = 48,
   parameter logic [31:0] MAGIC      = 32'h54414E4C,
   parameter int          HDR_OFFSET = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic                    start,
   input  logic                    stop,
   input  logic [7:0]              sel_flow,
   output logic [CNT_WIDTH-1:0]    res_frames,
   output logic [CNT_WIDTH-1:0]    res_bytes,
   output logic [CNT_WIDTH-1:0]    res_lost,
   output logic [CNT_WIDTH-1:0]    res_ooo,
   output logic [CNT_WIDTH-1:0]    res_bad,
   output logic [DATA_WIDTH-1:0]   axis_m_data,
   output logic [DATA_WIDTH/8-1:0] axis_m_keep,
   output logic                    axis_m_last,
   output logic [DATA_WIDTH/8-1:0] axis_m_user,
   output logic [ID_WIDTH-1:0]     axis_m_id,
   output logic                    axis_m_valid,
   input  logic                    axis_m_ready,
   input  logic [DATA_WIDTH-1:0]   axis_s_data,
   input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
   input  logic                    axis_s_last,
   input  logic [DATA_WIDTH/8-1:0] axis_s_user,
   input  logic [ID_WIDTH-1:0]     axis_s_id,
   input  logic                    axis_s_valid,
   output logic                    axis_s_ready
);
   localparam int FW = NUM_FLOWS > 1 ? $clog2(NUM_FLOWS) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state;
   logic sof, in_good, acc, hdr_ok, cnt_first, cnt_bytes, mid_next;
   logic [FW-1:0] cur_flow, fi, ci;
   logic [31:0] magic, seq_raw;
   logic [7:0] flow;
   logic [SEQ_WIDTH-1:0] seq, diff;
   logic [CNT_WIDTH-1:0] pop, bad;
   logic [CNT_WIDTH-1:0] frames [NUM_FLOWS];
   logic [CNT_WIDTH-1:0] bytes  [NUM_FLOWS];
   logic [CNT_WIDTH-1:0] lost   [NUM_FLOWS];
   logic [CNT_WIDTH-1:0] ooo    [NUM_FLOWS];
   logic [SEQ_WIDTH-1:0] exp_seq [NUM_FLOWS];

   function automatic logic [CNT_WIDTH-1:0] sat(input logic [CNT_WIDTH-1:0] a, input logic [CNT_WIDTH-1:0] b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   assign ready        = state == IDLE;
   assign axis_s_ready = !axis_m_valid || axis_m_ready;
   assign acc          = axis_s_valid && axis_s_ready;
   // header fields are big-endian byte sequences starting at HDR_OFFSET
   assign magic   = {axis_s_data[8*HDR_OFFSET+:8], axis_s_data[8*(HDR_OFFSET+1)+:8],
                     axis_s_data[8*(HDR_OFFSET+2)+:8], axis_s_data[8*(HDR_OFFSET+3)+:8]};
   assign flow    = axis_s_data[8*(HDR_OFFSET+4)+:8];
   assign seq_raw = {axis_s_data[8*(HDR_OFFSET+5)+:8], axis_s_data[8*(HDR_OFFSET+6)+:8],
                     axis_s_data[8*(HDR_OFFSET+7)+:8], axis_s_data[8*(HDR_OFFSET+8)+:8]};
   assign seq       = seq_raw[SEQ_WIDTH-1:0];
   assign fi        = flow[FW-1:0];
   assign ci        = sof ? fi : cur_flow;
   assign hdr_ok    = magic == MAGIC && 32'(flow) < NUM_FLOWS && &axis_s_keep[HDR_OFFSET+8:0];
   assign diff      = seq - exp_seq[fi];
   assign pop       = CNT_WIDTH'($countones(axis_s_keep));
   assign cnt_first = acc && sof && state == RUN;
   assign cnt_bytes = acc && (sof ? state == RUN && hdr_ok : in_good);
   // a frame is still open after this edge unless the last beat goes through now
   assign mid_next  = acc ? !axis_s_last : !sof;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         axis_m_valid <= 1'b0;
         axis_m_data  <= '0;
         axis_m_keep  <= '0;
         axis_m_last  <= 1'b0;
         axis_m_user  <= '0;
         axis_m_id    <= '0;
         sof          <= 1'b1;
      end else begin
         if (axis_s_ready) begin
            axis_m_valid <= axis_s_valid;
            axis_m_data  <= axis_s_data;
            axis_m_keep  <= axis_s_keep;
            axis_m_last  <= axis_s_last;
            axis_m_user  <= axis_s_user;
            axis_m_id    <= axis_s_id;
         end
         if (acc) sof <= axis_s_last;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else
         case (state)
            IDLE:    if (start) state <= RUN;
            RUN:     if (stop) state <= mid_next ? DRAIN : IDLE;
            DRAIN:   if (acc && axis_s_last) state <= IDLE;
            default: state <= IDLE;
         endcase

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         in_good  <= 1'b0;
         cur_flow <= '0;
         bad      <= '0;
         for (int i = 0; i < NUM_FLOWS; i++) begin
            frames[i]  <= '0;
            bytes[i]   <= '0;
            lost[i]    <= '0;
            ooo[i]     <= '0;
            exp_seq[i] <= '0;
         end
      end else if (state == IDLE && start) begin
         in_good <= 1'b0;
         bad     <= '0;
         for (int i = 0; i < NUM_FLOWS; i++) begin
            frames[i]  <= '0;
            bytes[i]   <= '0;
            lost[i]    <= '0;
            ooo[i]     <= '0;
            exp_seq[i] <= '0;
         end
      end else begin
         if (acc && sof) begin
            in_good  <= state == RUN && hdr_ok;
            cur_flow <= fi;
         end
         if (cnt_first && !hdr_ok) bad <= sat(bad, CNT_WIDTH'(1));
         if (cnt_first && hdr_ok) begin
            frames[fi] <= sat(frames[fi], CNT_WIDTH'(1));
            if (!diff[SEQ_WIDTH-1]) begin
               lost[fi]    <= sat(lost[fi], CNT_WIDTH'(diff));
               exp_seq[fi] <= seq + 1'b1;
            end else ooo[fi] <= sat(ooo[fi], CNT_WIDTH'(1));
         end
         if (cnt_bytes) bytes[ci] <= sat(bytes[ci], pop);
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         res_frames <= '0;
         res_bytes  <= '0;
         res_lost   <= '0;
         res_ooo    <= '0;
         res_bad    <= '0;
      end else begin
         res_frames <= 32'(sel_flow) < NUM_FLOWS ? frames[sel_flow[FW-1:0]] : '0;
         res_bytes  <= 32'(sel_flow) < NUM_FLOWS ? bytes[sel_flow[FW-1:0]]  : '0;
         res_lost   <= 32'(sel_flow) < NUM_FLOWS ? lost[sel_flow[FW-1:0]]   : '0;
         res_ooo    <= 32'(sel_flow) < NUM_FLOWS ? ooo[sel_flow[FW-1:0]]    : '0;
         res_bad    <= bad;
      end
endmodule

// File: tb/tb_frame_checker_multiflow.sv
// tb_frame_checker_multiflow: scoreboarded stream pass-through plus a frame-level statistics model.
module tb_frame_checker_multiflow;
   localparam int DW = 512, KW = DW/8, IW = 3, NF = 4, HO = 14, CW = 48;
   localparam logic [31:0] MG = 32'h54414E4C;
   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic [KW-1:0] u;
      logic [IW-1:0] id;
   } beat_t;

   logic clk = 0, rst, ready, start, stop;
   logic [7:0] sel_flow;
   logic [CW-1:0] res_frames, res_bytes, res_lost, res_ooo, res_bad;
   logic [DW-1:0] m_data, s_data;
   logic [KW-1:0] m_keep, m_user, s_keep, s_user;
   logic [IW-1:0] m_id, s_id;
   logic m_last, m_valid, m_ready, s_last, s_valid, s_ready;
   always #5 clk = ~clk;

   frame_checker_multiflow dut (
      .clk(clk), .rst(rst), .ready(ready), .start(start), .stop(stop), .sel_flow(sel_flow),
      .res_frames(res_frames), .res_bytes(res_bytes), .res_lost(res_lost), .res_ooo(res_ooo),
      .res_bad(res_bad), .axis_m_data(m_data), .axis_m_keep(m_keep), .axis_m_last(m_last),
      .axis_m_user(m_user), .axis_m_id(m_id), .axis_m_valid(m_valid), .axis_m_ready(m_ready),
      .axis_s_data(s_data), .axis_s_keep(s_keep), .axis_s_last(s_last), .axis_s_user(s_user),
      .axis_s_id(s_id), .axis_s_valid(s_valid), .axis_s_ready(s_ready));

   int tests = 0, fails = 0, nbeat = 0;
   bit bp_en = 0, running = 0;
   beat_t exp_q[$];
   longint unsigned mf[NF], mb[NF], ml[NF], mo[NF], mbad;
   logic [31:0] mexp[NF];

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", n, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      m_ready = !bp_en || ($urandom_range(0, 99) >= 30);
   end

   // monitor: every beat leaving the slice must equal the next beat that entered it
   always @(negedge clk)
      if (!rst && m_valid && m_ready) begin
         beat_t g, e;
         g = '{d: m_data, k: m_keep, l: m_last, u: m_user, id: m_id};
         tests++;
         nbeat++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL stream: unexpected beat %0d with no pending input", nbeat);
         end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
               fails++;
               $display("FAIL stream beat %0d: got last=%b keep=%h id=%0d d[63:0]=%h, expected last=%b keep=%h id=%0d d[63:0]=%h",
                        nbeat, g.l, g.k, g.id, g.d[63:0], e.l, e.k, e.id, e.d[63:0]);
            end
         end
      end

   task automatic send_beat(input beat_t b);
      int n = 0;
      {s_data, s_keep, s_last, s_user, s_id} = {b.d, b.k, b.l, b.u, b.id};
      s_valid = 1;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         if (++n > 2000) begin
            fails++;
            $display("FAIL send_beat: s_ready stuck low");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1);
         end
      end
      exp_q.push_back(b);
      @(posedge clk); #1;
      s_valid = 0;
   endtask

   function automatic logic [KW-1:0] keep_n(input int n);
      logic [KW-1:0] k = '0;
      for (int i = 0; i < n; i++) k[i] = 1'b1;
      return k;
   endfunction

   function automatic void model_frame(input int f, input logic [31:0] seq, input logic [31:0] mg,
                                       input logic [KW-1:0] fk, input longint unsigned by);
      logic [31:0] d;
      if (mg != MG || f >= NF || !(&fk[HO+8:0])) mbad++;
      else begin
         mf[f]++;
         mb[f] += by;
         d = seq - mexp[f];
         if (d < 32'h8000_0000) begin
            ml[f] += d;
            mexp[f] = seq + 1;
         end else mo[f]++;
      end
   endfunction

   task automatic send_frame(input int f, input logic [31:0] seq, input int nb, input int last_n,
                             input logic [31:0] mg, input int stop_at);
      beat_t b;
      logic [KW-1:0] fk = '0;
      longint unsigned by = 0;
      bit cnt = running;
      for (int i = 0; i < nb; i++) begin
         for (int j = 0; j < DW/32; j++) b.d[32*j+:32] = $urandom;
         b.k = (i == nb-1) ? keep_n(last_n) : '1;
         b.l = i == nb-1;
         b.u = {$urandom, $urandom};
         b.id = IW'($urandom);
         if (i == 0) begin
            for (int j = 0; j < 4; j++) b.d[8*(HO+j)+:8] = mg[8*(3-j)+:8];
            b.d[8*(HO+4)+:8] = 8'(f);
            for (int j = 0; j < 4; j++) b.d[8*(HO+5+j)+:8] = seq[8*(3-j)+:8];
            fk = b.k;
         end
         by += longint'($countones(b.k));
         if (stop_at == i+1) stop = 1;
         send_beat(b);
         stop = 0;
         if (stop_at == i+1) begin
            running = 0;
            if (i < nb-1) chk("drain_not_ready", ready, 0);
         end
      end
      if (cnt) model_frame(f, seq, mg, fk, by);
   endtask

   task automatic do_start();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      running = 1;
      mbad = 0;
      for (int i = 0; i < NF; i++) begin
         mf[i] = 0; mb[i] = 0; ml[i] = 0; mo[i] = 0; mexp[i] = 0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", n >= 5000, 0);
   endtask

   task automatic sel(input logic [7:0] f);
      sel_flow = f;
      @(posedge clk); #1;
   endtask

   task automatic read_check();
      for (int f = 0; f < NF; f++) begin
         sel(8'(f));
         chk($sformatf("frames[%0d]", f), res_frames, mf[f]);
         chk($sformatf("bytes[%0d]", f), res_bytes, mb[f]);
         chk($sformatf("lost[%0d]", f), res_lost, ml[f]);
         chk($sformatf("ooo[%0d]", f), res_ooo, mo[f]);
      end
      chk("bad", res_bad, mbad);
   endtask

   initial begin
      int f, nb, ln;
      logic [31:0] sq, mg;
      logic [31:0] t2[5] = '{0, 1, 5, 3, 6};
      logic [31:0] t3[7] = '{32'h7FFFFFFE, 32'hBFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1, 0};
      rst = 1; start = 0; stop = 0; sel_flow = 0; s_valid = 0; m_ready = 1;
      {s_data, s_keep, s_last, s_user, s_id} = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst_ready", ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_frames", res_frames, 0);
      chk("rst_bad", res_bad, 0);
      rst = 0;
      @(posedge clk); #1;
      do_start();
      chk("run_not_ready", ready, 0);
      for (int s = 0; s < 10; s++) send_frame(0, s, 1, 64, MG, 0);
      foreach (t2[i]) send_frame(1, t2[i], 1, 64, MG, 0);
      send_frame(1, 7, 1, 64, MG, 0);
      foreach (t3[i]) send_frame(2, t3[i], 1, 40, MG, 0);
      send_frame(0, 10, 1, 64, 32'hDEADBEEF, 0);
      send_frame(NF, 0, 1, 64, MG, 0);
      drain();
      read_check();
      sel(0);
      chk("t1_frames", res_frames, 10);
      chk("t1_bytes", res_bytes, 640);
      sel(1);
      chk("t2_lost", res_lost, 3);
      chk("t2_ooo", res_ooo, 1);
      chk("t2_frames", res_frames, 6);
      sel(2);
      chk("t3_ooo", res_ooo, 1);
      chk("t3_lost", res_lost, 64'hFFFFFFFC);
      chk("t4_bad", res_bad, 2);
      sel(200);
      chk("t4_sel200_frames", res_frames, 0);
      chk("t4_sel200_bytes", res_bytes, 0);
      send_frame(3, 0, 3, 10, MG, 2);
      chk("t5_ready", ready, 1);
      send_frame(3, 1, 1, 64, MG, 0);
      drain();
      read_check();
      sel(3);
      chk("t5_bytes", res_bytes, 138);
      chk("t5_frames", res_frames, 1);
      do_start();
      bp_en = 1;
      for (int i = 0; i < 1000; i++) begin
         f = $urandom_range(0, NF);
         nb = $urandom_range(1, 3);
         ln = (nb == 1 && $urandom_range(0, 9) == 0) ? $urandom_range(1, 22) : $urandom_range(23, 64);
         if (nb > 1) ln = $urandom_range(1, 64);
         mg = ($urandom_range(0, 19) == 0) ? $urandom : MG;
         sq = (f < NF) ? mexp[f] + 32'($urandom_range(0, 8)) - 32'd3 : $urandom;
         send_frame(f, sq, nb, ln, mg, 0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      stop = 1;
      @(posedge clk); #1;
      stop = 0;
      running = 0;
      chk("t6_ready", ready, 1);
      bp_en = 0;
      drain();
      read_check();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
